// File: rtl/fp_ie_pkg.sv
// Shared parameters, FSM states and field helpers for the sequential FP multiplier.
// Field order in a packed word is {sign, exp, mant}.
package fp_ie_pkg;

    localparam int unsigned M     = 8;
    localparam int unsigned N     = 23;
    localparam int unsigned W     = M + N + 1;
    localparam int unsigned BIAS  = (1 << (M - 1)) - 1;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned ACC_W = 2 * N + 2;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

    function automatic logic get_sign(input logic [W-1:0] w);
        return w[W-1];
    endfunction

    function automatic logic [M-1:0] get_exp(input logic [W-1:0] w);
        return w[W-2:N];
    endfunction

    function automatic logic [N-1:0] get_mant(input logic [W-1:0] w);
        return w[N-1:0];
    endfunction

endpackage

// File: rtl/mul_seq_ie_if.sv
// Operand/result handshake bundle for mul_seq_ie.
// The master is the operand producer and the result consumer; the slave is the multiplier.
interface mul_seq_ie_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [fp_ie_pkg::W-1:0]  a_in;
    logic [fp_ie_pkg::W-1:0]  b_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [fp_ie_pkg::W-1:0]  c_out;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, c_out
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, c_out
    );

endinterface

// File: rtl/mant_mul_iter.sv
// Iterative shift-add mantissa multiplier: one partial product per cycle, N+1 cycles.
// done_o stays high after the last iteration until the next start.
module mant_mul_iter
    import fp_ie_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [N:0]       ma_i,
    input  logic [N:0]       mb_i,
    output logic             done_o,
    output logic [ACC_W-1:0] acc_o
);

    logic [N:0]       ma_q, ma_d;
    logic [N:0]       mb_q, mb_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        ma_d   = ma_q;
        mb_d   = mb_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (start_i) begin
            ma_d   = ma_i;
            mb_d   = mb_i;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            if (mb_q[cnt_q]) begin
                acc_d = acc_q + ({{(ACC_W - N - 1){1'b0}}, ma_q} << cnt_q);
            end
            if (cnt_q == CNT_W'(N)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q   <= '0;
            mb_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign acc_o  = acc_q;

endmodule

// File: rtl/mul_seq_ie.sv
// Sequential flush-to-zero, truncating FP multiplier with a valid/ready handshake.
// Handshake FSM, exponent arithmetic and result select; mantissa product in mant_mul_iter.
module mul_seq_ie
    import fp_ie_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mul_seq_ie_if.slave  bus
);

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic [M-1:0]     ea_q, ea_d;
    logic [M-1:0]     eb_q, eb_d;
    logic             zero_q, zero_d;
    logic [W-1:0]     c_out_q, c_out_d;

    logic             accept;
    logic             mul_done;
    logic [ACC_W-1:0] acc;
    logic [M+1:0]     e;
    logic [N-1:0]     mant;
    logic             underflow;
    logic             overflow;
    logic [W-1:0]     result;

    assign accept = bus.in_valid && (state_q == IDLE);

    mant_mul_iter u_mant_mul_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept),
        .ma_i    ({1'b1, get_mant(bus.a_in)}),
        .mb_i    ({1'b1, get_mant(bus.b_in)}),
        .done_o  (mul_done),
        .acc_o   (acc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)        state_d = MUL;
            MUL:  if (mul_done)      state_d = NORM;
            NORM:                    state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Exponent kept on M+2 bits so the top bit reads as the sign of a two's-complement value.
    always_comb begin
        e = (M+2)'(ea_q) + (M+2)'(eb_q) - (M+2)'(BIAS) + (M+2)'(acc[ACC_W-1]);
        if (acc[ACC_W-1]) begin
            mant = acc[2*N:N+1];
        end else begin
            mant = acc[2*N-1:N];
        end
        underflow = zero_q || e[M+1] || (e == '0);
        overflow  = (e[M:0] >= (M+1)'((1 << M) - 1));
        if (underflow) begin
            result = '0;
        end else if (overflow) begin
            result = {sign_q, {M{1'b1}}, {N{1'b0}}};
        end else begin
            result = {sign_q, e[M-1:0], mant};
        end
    end

    always_comb begin
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        zero_d  = zero_q;
        c_out_d = c_out_q;
        if (accept) begin
            sign_d = get_sign(bus.a_in) ^ get_sign(bus.b_in);
            ea_d   = get_exp(bus.a_in);
            eb_d   = get_exp(bus.b_in);
            zero_d = (get_exp(bus.a_in) == '0) || (get_exp(bus.b_in) == '0);
        end
        if (state_q == NORM) begin
            c_out_d = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            zero_q  <= 1'b0;
            c_out_q <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            zero_q  <= zero_d;
            c_out_q <= c_out_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.c_out     = c_out_q;
    end

endmodule

// File: tb/tb_mul_seq_ie.sv
// Directed-vector bench for mul_seq_ie with an arithmetic reference model and a
// per-cycle compare process on the result port.
module tb_mul_seq_ie;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_seq_ie_if bus ();

    mul_seq_ie dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_c  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: exact 48-bit product, truncate, flush tiny/zero, saturate to infinity.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic [22:0] mant;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'h0 || b[30:23] == 8'h0) return 32'h0;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            mant = p[46:24];
            e++;
        end else begin
            mant = p[45:23];
        end
        if (e <= 0) return 32'h0;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        return {s, e[7:0], mant};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1) begin
            check("cmp_c_out", bus.c_out, exp_c);
            check("cmp_in_ready_low", 32'(bus.in_ready), 32'h0);
        end
    end

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'h1);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        exp_c        = model(a, b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a_in     = $urandom;
        bus.b_in     = $urandom;
        check("accepted_busy", 32'(bus.in_ready), 32'h0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid === 1'b1) break;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("handshake_out_valid", 32'(bus.out_valid), 32'h0);
        check("handshake_in_ready", 32'(bus.in_ready), 32'h1);
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit);
        int lat;
        check({"model_", name}, model(a, b), lit);
        accept(a, b);
        wait_valid(lat);
        check({"latency_", name}, 32'(lat), 32'd26);
        check({"result_", name}, bus.c_out, lit);
        take_result();
    endtask

    initial begin
        int lat;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_in      = 32'h0;
        bus.b_in      = 32'h0;
        #12;
        check("reset_in_ready", 32'(bus.in_ready), 32'h1);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_c_out", bus.c_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("basic",     32'h40000000, 32'h40400000, 32'h40C00000);
        run("norm_inc",  32'h3FC00000, 32'hBFC00000, 32'hC0100000);
        run("truncate",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
        run("zero_a",    32'h00000000, 32'h40400000, 32'h00000000);
        run("neg_zero",  32'h80000000, 32'hC0000000, 32'h00000000);
        run("overflow",  32'h7F000000, 32'h40000000, 32'h7F800000);
        run("underflow", 32'h00800000, 32'h3F000000, 32'h00000000);

        // Backpressure: result held while a second pair is offered and must be ignored.
        accept(32'h40000000, 32'h40400000);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd26);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a_in     = 32'h3F800000;
            bus.b_in     = 32'h40800000;
            check("bp_c_out_stable", bus.c_out, 32'h40C00000);
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_out_valid", 32'(bus.out_valid), 32'h1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'h0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
        check("bp_c_out_kept", bus.c_out, 32'h40C00000);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        check("bp_nothing_queued", 32'(seen), 32'h0);

        // Reset in the middle of the mantissa iterations.
        accept(32'h40000000, 32'h40400000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'h0);
        check("abort_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_reset", 32'h40000000, 32'h40000000, 32'h40800000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
